stream_deserializer: RTL
========================

# stream_deserializer

Capture stage directly downstream of the single-bit registered datapath: it samples the serial `out` stream from that stage, packs consecutive bits LSB-first into WIDTH-bit words, and buffers them in a small FIFO. Words leave through a valid/ready handshake. The block also records overflow when the consumer stalls, so the upstream bit stream can be checked word by word in simulation and on silicon.

## Interface
- WIDTH, 8, bits per packed word (≥2)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data, driven by the upstream stage's `out`
- din_en  in  1  sample strobe; din is accepted on a rising edge where din_en=1
- clr_ovf  in  1  synchronous clear of the overflow flag and drop count
- word_data  out  WIDTH  head-of-FIFO word, valid only while word_valid=1
- word_valid  out  1  FIFO non-empty
- word_ready  in  1  consumer accepts the head word when word_valid=1
- fill  out  log2(DEPTH)+1  number of stored words, 0..DEPTH
- bit_idx  out  log2(WIDTH)  bits collected toward the current word, 0..WIDTH-1
- overflow  out  1  sticky; a completed word was dropped because the FIFO was full
- drop_cnt  out  8  dropped-word count, saturates at 255

## Operation
- Shift stage: on each edge with din_en=1, din is written into bit position bit_idx of the assembly register and bit_idx increments. The first bit received becomes word bit 0 (LSB-first).
- Word completion: the edge that accepts a bit while bit_idx=WIDTH-1 forms {din, assembly[WIDTH-2:0]}, attempts a FIFO push on that same edge, and wraps bit_idx to 0.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits and a fill counter. The pointers wrap modulo DEPTH. word_data is the entry at the read pointer.
- Pop: occurs on an edge where word_valid=1 and word_ready=1. word_ready while empty has no effect.
- Push while full (fill=DEPTH, no pop on the same edge): the word is discarded, FIFO contents are unchanged, overflow is set to 1, and drop_cnt increments (saturating).
- Push and pop on the same edge: both take effect and fill is unchanged. This applies even at fill=DEPTH, where the push succeeds and nothing is dropped.
- clr_ovf=1: on that edge overflow←0 and drop_cnt←0. If a drop occurs on the same edge, the drop wins: overflow←1 and drop_cnt←1.
- din_en=0 freezes the shift stage. FIFO pops continue independently.
- No data-dependent state machine. The two counters (bit_idx and fill) are the only control state.

## Timing
- Reset (asynchronous, takes effect immediately, held while rst=1) sets: bit_idx=0, assembly register=0, both pointers=0, fill=0, word_valid=0, word_data=0 (FIFO storage reset to 0), overflow=0, drop_cnt=0.
- Reset asserted mid-word discards the partial word. Reset asserted mid-FIFO discards all stored words. No output glitches to a non-reset value while rst=1.
- Latency: a word completed on edge N has word_valid=1 and the word on word_data in the cycle after edge N, if the FIFO was empty. A word cannot be popped on its own push edge.
- Throughput: one word per WIDTH din_en strobes. The consumer can pop one word per cycle.
- word_data and word_valid are registered state only. There is no combinational path from word_ready, din or din_en to any output.
- fill, word_valid and overflow update on the same edge as the event that changes them.

## Test plan
- Reset, then 16 strobes of din = 1,0,1,1,0,0,0,0, 0,1,0,1,0,1,0,1 with word_ready=1 → word 0x0D then word 0xAA each pop one cycle after completion; fill returns to 0; overflow=0.
- word_ready=0, 5 full words (0x01..0x05) → fill=4 after 4 words, 5th dropped, overflow=1, drop_cnt=1; draining yields 0x01..0x04 in order.
- At fill=4, complete word 0x77 on the same edge as a pop → no drop, fill stays 4, last entry read out is 0x77.
- 3 strobes of a word, then assert rst for 1 cycle → bit_idx=0, fill=0, word_valid=0; the next 8 strobes of 0xFF produce exactly 0xFF.
- Force 300 drops, then clr_ovf=1 for 1 cycle → drop_cnt saturates at 255 before the clear, and overflow=0, drop_cnt=0 after it.
- Toggle din_en randomly at 30% duty against a reference model over 10k cycles with random word_ready → output word sequence and drop_cnt match the model.

Source files
------------

// File: rtl/stream_deserializer.sv
// stream_deserializer
// Packs a strobed serial bit stream LSB-first into WIDTH-bit words and
// buffers the words in a DEPTH-entry FIFO with a valid/ready output.
// A completed word that finds the FIFO full (and not being popped on the
// same edge) is dropped and recorded in a sticky flag plus a saturating count.
module stream_deserializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_en,
    input  logic                       clr_ovf,
    output logic [WIDTH-1:0]           word_data,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic [$clog2(DEPTH):0]     fill,
    output logic [$clog2(WIDTH)-1:0]   bit_idx,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH);
    localparam int FW = PW + 1;

    logic [BW-1:0]    bit_idx_reg;
    logic [WIDTH-2:0] asm_reg;
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [FW-1:0]    fill_reg;
    logic [FW-1:0]    fill_next;
    logic             ovf_reg;
    logic [7:0]       drop_cnt_reg;
    logic [WIDTH-1:0] mem_reg [DEPTH];

    logic             last_bit;
    logic             complete;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;
    logic [WIDTH-1:0] new_word;
    logic [WIDTH-2:0] bit_sel;
    logic [DEPTH-1:0] wr_sel;

    assign last_bit = (bit_idx_reg == BW'(WIDTH - 1));
    assign complete = din_en && last_bit;
    assign full     = (fill_reg == FW'(DEPTH));
    assign pop      = (fill_reg != '0) && word_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok  = complete && (!full || pop);
    assign drop     = complete && full && !pop;
    assign new_word = {din, asm_reg};

    // One-hot write strobes for the assembly bits and the FIFO entries.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_bit_sel
            assign bit_sel[gi] = din_en && (bit_idx_reg == BW'(gi));
        end
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push_ok && (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Fill counter next value: push and pop together leave it unchanged.
    always_comb begin
        fill_next = fill_reg;
        case ({push_ok, pop})
            2'b10:   fill_next = fill_reg + FW'(1);
            2'b01:   fill_next = fill_reg - FW'(1);
            default: fill_next = fill_reg;
        endcase
    end

    // Shift stage: bit index counter and assembly register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_reg <= '0;
            asm_reg     <= '0;
        end else begin
            if (din_en) begin
                bit_idx_reg <= last_bit ? '0 : bit_idx_reg + BW'(1);
            end
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (bit_sel[i]) begin
                    asm_reg[i] <= din;
                end
            end
        end
    end

    // FIFO storage, pointers and fill count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fill_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem_reg[i] <= new_word;
                end
            end
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            fill_reg <= fill_next;
        end
    end

    // Overflow tracking; a drop on the clearing edge takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
            if (clr_ovf) begin
                drop_cnt_reg <= 8'd1;
            end else if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end else if (clr_ovf) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end
    end

    assign word_data  = mem_reg[rd_ptr_reg];
    assign word_valid = (fill_reg != '0);
    assign fill       = fill_reg;
    assign bit_idx    = bit_idx_reg;
    assign overflow   = ovf_reg;
    assign drop_cnt   = drop_cnt_reg;

endmodule
